icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped instruction cache serving the 3-way fetch stage: per-way combinational lookup of
//  WAY_NUM PCs, returns instruction + per-way hit. On miss, single-outstanding fill FSM issues one
//  BUS_LOAD to instruction memory, tracks returned tag, writes the 64-bit block. Sits between
//  if_stage (requester) and the Imem bus / memory arbiter (mem_req_accept_i).
// PARAMETERS
//  WAY_NUM        3    fetch ports (from `WAY_NUM)
//  ICACHE_LINES   32   lines; index = PC[7:3], tag = PC[31:8], word select = PC[2]
//  BLOCK_BITS     64   line size = `MEMORY_DATA_SIZE (two 32-bit instructions)
// PORTS
//  clock                 in   1              system clock
//  reset                 in   1              synchronous, active-high
//  proc2Icache_PC_i      in   WAY_NUM*32     fetch PC per way (way 0 = oldest)
//  fetch_en_i            in   1              lookup/miss launch enable (0 = fetch stalled)
//  icache2if_inst_o      out  WAY_NUM*32     instruction per way (0 when not valid)
//  icache2if_valid_o     out  WAY_NUM        per-way raw hit
//  proc2Imem_command_o   out  2              BUS_NONE / BUS_LOAD
//  proc2Imem_addr_o      out  32             block-aligned fill address ([2:0]=0)
//  mem_req_accept_i      in   1              arbiter grant for this cycle's command
//  Imem2proc_response_i  in   4              tag assigned to request; 0 = not accepted
//  Imem2proc_data_i      in   64             fill data
//  Imem2proc_tag_i       in   4              tag of data on bus; 0 = no data
// BEHAVIOUR
//  Lookup: combinational, same cycle. valid[i] = fetch_en_i & line_valid[idx_i] & (tag_i==stored).
//   inst[i] = PC[2] ? data[63:32] : data[31:0]. Ways may alias one line; all report independently.
//  Miss select: lowest-index way with valid[i]==0 while fetch_en_i=1; its block address is latched.
//  FSM: IDLE -> REQ -> WAIT -> IDLE.
//   IDLE: if miss & fetch_en_i, latch miss_addr = {PC[31:3],3'b0}, go REQ (same-cycle launch: command
//    driven combinationally from IDLE state with the miss address).
//   REQ: command=BUS_LOAD, addr=miss_addr held constant. Accepted iff mem_req_accept_i=1 &
//    response!=0 -> latch mem_tag=response, go WAIT. Otherwise stay REQ; no cancel on PC change.
//   WAIT: command=BUS_NONE. When Imem2proc_tag_i==mem_tag (nonzero): write data/tag, set line valid,
//    clear mem_tag, go IDLE. Other tags ignored.
//  Fill/lookup same cycle, same line: lookup sees old contents (miss); hit on following cycle.
//  Fill latency minimum: miss cycle N request, accept N, data at N+k, hit at N+k+1.
//  PC redirect during WAIT: fill completes and is written anyway (line is still correct data).
//  Tag 0 on Imem2proc_tag_i never matches. Response and tag on same cycle for same request: tag
//   ignored (mem_tag not yet latched) -- memory guarantees data strictly after response.
//  Reset (synchronous): all line_valid=0, FSM=IDLE, mem_tag=0, command=BUS_NONE, addr=0,
//   valid_o=0, inst_o=0. Reset mid-WAIT discards the outstanding fill; late tag is ignored.
// CONFIGURATION
//  ICACHE_PREFETCH_EN defined: after a demand fill write, if line miss_addr+8 is not valid, FSM goes
//   to PREFETCH_REQ/PREFETCH_WAIT (same rules as REQ/WAIT, addr=miss_addr+8) before IDLE. A demand
//   miss arising during prefetch waits until prefetch completes; if demand address equals prefetch
//   address no second request is issued. Addr wraps mod 2^32.
//  Not defined: no prefetch states; FSM returns to IDLE directly after every fill.
// TESTING
//  1 Reset then PCs {0,4,8}, fetch_en=1 -> valid=000, BUS_LOAD addr 0x0; accept+response=3 -> WAIT.
//  2 Tag 3, data 0x00000013_00100093 -> next cycle PCs {0,4,8}: valid=011, inst0=0x00100093,
//    inst1=0x00000013; new BUS_LOAD addr 0x8.
//  3 REQ with mem_req_accept_i=0 for 4 cycles (response=5) -> command/addr held, still REQ; grant
//    on cycle 5 -> mem_tag=5.
//  4 In WAIT tag=5, bus delivers tag 2 then tag 5 -> tag-2 data ignored, line written only on tag 5.
//  5 PC 0x100 and 0x0 both index 0: fill 0x100 after 0x0 -> lookup 0x0 misses, 0x100 hits.
//  6 Reset asserted in WAIT (tag 7), tag 7 returns after reset -> no line valid, FSM IDLE.
//    With ICACHE_PREFETCH_EN: miss 0x20 fill -> second BUS_LOAD 0x28 issued without new miss.

Source files
------------

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache for the multi-way fetch stage.
//               Combinational per-way lookup; one outstanding BUS_LOAD fill at
//               a time, matched back by memory tag.
//               Optional build macro: ICACHE_PREFETCH_EN (next-line prefetch
//               after every demand fill).
// Revision    : 1.0 - initial release
// ============================================================================
module icache #(
  parameter int WAY_NUM      = 3,
  parameter int ICACHE_LINES = 32,
  parameter int BLOCK_BITS   = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WAY_NUM*32-1:0]   proc2Icache_PC_i,
  input  logic                    fetch_en_i,
  output logic [WAY_NUM*32-1:0]   icache2if_inst_o,
  output logic [WAY_NUM-1:0]      icache2if_valid_o,
  output logic [1:0]              proc2Imem_command_o,
  output logic [31:0]             proc2Imem_addr_o,
  input  logic                    mem_req_accept_i,
  input  logic [3:0]              Imem2proc_response_i,
  input  logic [BLOCK_BITS-1:0]   Imem2proc_data_i,
  input  logic [3:0]              Imem2proc_tag_i
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 29 - IDX_W;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_REQ     = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT    = 3'd2;
  localparam logic [STATE_W-1:0] S_PF_REQ  = 3'd3;
  localparam logic [STATE_W-1:0] S_PF_WAIT = 3'd4;

  // Cache storage; only the valid bits need a reset value.
  logic [BLOCK_BITS-1:0]   r_data [ICACHE_LINES];
  logic [TAG_W-1:0]        r_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] r_line_valid;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic [28:0]        r_miss_blk;   // block address (PC[31:3]) of the fill in flight
  logic [3:0]         r_mem_tag;    // 0 means no fill outstanding

  logic        w_miss;
  logic [28:0] w_miss_blk;
  logic        w_accept;
  logic        w_requesting;
  logic        w_waiting;
  logic        w_fill;
  logic        w_pf_present;
  logic [28:0] w_pf_blk;

  // Per-way lookup; ways may alias the same line and report independently.
  for (genvar i = 0; i < WAY_NUM; i++) begin : g_way
    logic [31:0]      w_pc;
    logic [IDX_W-1:0] w_idx;
    logic             w_hit;
    logic [1:0]       w_unused_pc;
    assign w_pc        = proc2Icache_PC_i[i*32 +: 32];
    assign w_idx       = w_pc[3 +: IDX_W];
    assign w_unused_pc = w_pc[1:0];
    assign w_hit       = fetch_en_i & ~reset & r_line_valid[w_idx] &
                         (r_tag[w_idx] == w_pc[31 -: TAG_W]);
    assign icache2if_valid_o[i]       = w_hit;
    assign icache2if_inst_o[i*32 +: 32] = !w_hit  ? 32'd0 :
                                          w_pc[2] ? r_data[w_idx][63:32] :
                                                    r_data[w_idx][31:0];
  end

  // Pick the lowest-index missing way as the demand miss candidate.
  always_comb begin
    w_miss     = 1'b0;
    w_miss_blk = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (!icache2if_valid_o[i]) begin
        w_miss     = fetch_en_i;
        w_miss_blk = proc2Icache_PC_i[i*32+3 +: 29];
      end
    end
  end

  assign w_accept     = mem_req_accept_i & (|Imem2proc_response_i);
  assign w_requesting = ((r_state == S_IDLE) & w_miss) | (r_state == S_REQ) |
                        (r_state == S_PF_REQ);
  assign w_waiting    = (r_state == S_WAIT) | (r_state == S_PF_WAIT);
  // Tag 0 never matches because r_mem_tag is cleared whenever nothing is pending.
  assign w_fill       = w_waiting & (|r_mem_tag) & (Imem2proc_tag_i == r_mem_tag);

`ifdef ICACHE_PREFETCH_EN
  assign w_pf_blk     = r_miss_blk + 29'd1;
  assign w_pf_present = r_line_valid[w_pf_blk[IDX_W-1:0]] &
                        (r_tag[w_pf_blk[IDX_W-1:0]] == w_pf_blk[28 -: TAG_W]);
`else
  assign w_pf_blk     = '0;
  assign w_pf_present = 1'b1;
`endif

  // Fill FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Fill FSM next-state: a miss in IDLE may be granted in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_miss) w_state_next = w_accept ? S_WAIT : S_REQ;
      S_REQ:     if (w_accept) w_state_next = S_WAIT;
      S_WAIT:    if (w_fill) w_state_next = w_pf_present ? S_IDLE : S_PF_REQ;
`ifdef ICACHE_PREFETCH_EN
      S_PF_REQ:  if (w_accept) w_state_next = S_PF_WAIT;
      S_PF_WAIT: if (w_fill) w_state_next = S_IDLE;
`endif
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Bus command: launched combinationally from IDLE, held while requesting.
  always_comb begin
    proc2Imem_command_o = BUS_NONE;
    proc2Imem_addr_o    = 32'd0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            proc2Imem_command_o = BUS_LOAD;
            proc2Imem_addr_o    = {w_miss_blk, 3'b000};
          end
        end
        S_REQ, S_PF_REQ: begin
          proc2Imem_command_o = BUS_LOAD;
          proc2Imem_addr_o    = {r_miss_blk, 3'b000};
        end
        default: ;
      endcase
    end
  end

  // Miss address, outstanding memory tag and line valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_miss_blk   <= '0;
      r_mem_tag    <= '0;
      r_line_valid <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_miss)
        r_miss_blk <= w_miss_blk;
      if (w_requesting && w_accept)
        r_mem_tag <= Imem2proc_response_i;
      if (w_fill) begin
        r_mem_tag <= '0;
        r_line_valid[r_miss_blk[IDX_W-1:0]] <= 1'b1;
        if ((r_state == S_WAIT) && !w_pf_present)
          r_miss_blk <= w_pf_blk;
      end
    end
  end

  // Line data/tag write on a matching fill return.
  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_data[r_miss_blk[IDX_W-1:0]] <= Imem2proc_data_i;
      r_tag[r_miss_blk[IDX_W-1:0]]  <= r_miss_blk[28 -: TAG_W];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache. Expected fill request
//               addresses are queued when a miss is provoked and popped when
//               the bench grants the matching BUS_LOAD. Honours the
//               ICACHE_PREFETCH_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic        clock;
  logic        reset;
  logic [95:0] proc2Icache_PC_i;
  logic        fetch_en_i;
  logic [95:0] icache2if_inst_o;
  logic [2:0]  icache2if_valid_o;
  logic [1:0]  proc2Imem_command_o;
  logic [31:0] proc2Imem_addr_o;
  logic        mem_req_accept_i;
  logic [3:0]  Imem2proc_response_i;
  logic [63:0] Imem2proc_data_i;
  logic [3:0]  Imem2proc_tag_i;

  int          n_vec;
  int          n_err;
  logic [31:0] q_req [$];

  icache dut (
    .clock                (clock),
    .reset                (reset),
    .proc2Icache_PC_i     (proc2Icache_PC_i),
    .fetch_en_i           (fetch_en_i),
    .icache2if_inst_o     (icache2if_inst_o),
    .icache2if_valid_o    (icache2if_valid_o),
    .proc2Imem_command_o  (proc2Imem_command_o),
    .proc2Imem_addr_o     (proc2Imem_addr_o),
    .mem_req_accept_i     (mem_req_accept_i),
    .Imem2proc_response_i (Imem2proc_response_i),
    .Imem2proc_data_i     (Imem2proc_data_i),
    .Imem2proc_tag_i      (Imem2proc_tag_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pcs(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
    proc2Icache_PC_i = {p2, p1, p0};
  endtask

  // Wait (bounded) for a BUS_LOAD, grant it with the given tag, score its address.
  task automatic grant(input logic [3:0] resp);
    int n;
    n = 0;
    #1;
    while (proc2Imem_command_o != BUS_LOAD && n < 8) begin
      tick();
      n++;
    end
    check("req_cmd", proc2Imem_command_o, BUS_LOAD);
    mem_req_accept_i     = 1'b1;
    Imem2proc_response_i = resp;
    #1;
    if (q_req.size() == 0) check("sb_depth", q_req.size(), 1);
    else                   check("req_addr", proc2Imem_addr_o, q_req.pop_front());
    tick();
    mem_req_accept_i     = 1'b0;
    Imem2proc_response_i = 4'd0;
  endtask

  // Present one fill return for a single cycle.
  task automatic deliver(input logic [3:0] tag, input logic [63:0] data);
    Imem2proc_tag_i  = tag;
    Imem2proc_data_i = data;
    #1;
    tick();
    Imem2proc_tag_i  = 4'd0;
    Imem2proc_data_i = 64'd0;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    fetch_en_i = 1'b0;
    proc2Icache_PC_i = '0;
    mem_req_accept_i = 1'b0;
    Imem2proc_response_i = 4'd0;
    Imem2proc_tag_i = 4'd0;
    Imem2proc_data_i = 64'd0;
    tick();
    tick();
    #1;
    check("rst_cmd",   proc2Imem_command_o, BUS_NONE);
    check("rst_addr",  proc2Imem_addr_o, 32'd0);
    check("rst_valid", icache2if_valid_o, 3'b000);
    check("rst_inst",  icache2if_inst_o, 64'd0);
    reset = 1'b0;
    tick();

`ifdef ICACHE_PREFETCH_EN
    // Demand fill of 0x20 triggers a next-line prefetch of 0x28.
    set_pcs(32'h20, 32'h20, 32'h20);
    fetch_en_i = 1'b1;
    #1;
    q_req.push_back(32'h20);
    grant(4'd1);
    fetch_en_i = 1'b0;
    deliver(4'd1, 64'h0000_0002_0000_0001);
    check("pf_cmd",  proc2Imem_command_o, BUS_LOAD);
    check("pf_addr", proc2Imem_addr_o, 32'h28);
    q_req.push_back(32'h28);
    grant(4'd2);
    deliver(4'd2, 64'h0000_0004_0000_0003);
    set_pcs(32'h28, 32'h2C, 32'h20);
    fetch_en_i = 1'b1;
    #1;
    check("pf_valid", icache2if_valid_o, 3'b111);
    check("pf_inst1", icache2if_inst_o[63:32], 32'h4);
    check("pf_idle",  proc2Imem_command_o, BUS_NONE);
`else
    // 1: cold miss on PCs {0,4,8}, request granted the same cycle.
    set_pcs(32'h0, 32'h4, 32'h8);
    fetch_en_i = 1'b1;
    #1;
    check("t1_valid", icache2if_valid_o, 3'b000);
    q_req.push_back(32'h0);
    grant(4'd3);
    #1;
    check("t1_wait_cmd", proc2Imem_command_o, BUS_NONE);

    // 2: fill tag 3; lookup same cycle still misses, next cycle hits.
    Imem2proc_tag_i  = 4'd3;
    Imem2proc_data_i = 64'h00000013_00100093;
    #1;
    check("t2_same_cycle", icache2if_valid_o, 3'b000);
    tick();
    Imem2proc_tag_i  = 4'd0;
    Imem2proc_data_i = 64'd0;
    #1;
    check("t2_valid", icache2if_valid_o, 3'b011);
    check("t2_inst0", icache2if_inst_o[31:0],  32'h00100093);
    check("t2_inst1", icache2if_inst_o[63:32], 32'h00000013);
    check("t2_inst2", icache2if_inst_o[95:64], 32'h0);
    check("t2_cmd",   proc2Imem_command_o, BUS_LOAD);
    check("t2_addr",  proc2Imem_addr_o, 32'h8);
    q_req.push_back(32'h8);

    // 3: request held while the arbiter refuses for four cycles.
    Imem2proc_response_i = 4'd5;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_hold_cmd",  proc2Imem_command_o, BUS_LOAD);
      check("t3_hold_addr", proc2Imem_addr_o, 32'h8);
      tick();
    end
    grant(4'd5);

    // 4: a foreign tag is ignored; only tag 5 writes the line.
    deliver(4'd2, 64'hBAD0BAD0_BAD1BAD1);
    check("t4_ignored", icache2if_valid_o, 3'b011);
    check("t4_inst2",   icache2if_inst_o[95:64], 32'h0);
    check("t4_wait",    proc2Imem_command_o, BUS_NONE);
    deliver(4'd5, 64'h22222222_11111111);
    check("t4_valid", icache2if_valid_o, 3'b111);
    check("t4_inst2", icache2if_inst_o[95:64], 32'h11111111);
    set_pcs(32'h8, 32'hC, 32'h0);
    #1;
    check("t4_inst1", icache2if_inst_o[63:32], 32'h22222222);
    check("t4_idle",  proc2Imem_command_o, BUS_NONE);

    // 5: 0x100 aliases line 0 and evicts 0x0.
    set_pcs(32'h100, 32'h0, 32'h104);
    #1;
    q_req.push_back(32'h100);
    grant(4'd6);
    deliver(4'd6, 64'h33333333_44444444);
    check("t5_valid", icache2if_valid_o, 3'b101);
    check("t5_inst0", icache2if_inst_o[31:0],  32'h44444444);
    check("t5_inst1", icache2if_inst_o[63:32], 32'h0);
    check("t5_inst2", icache2if_inst_o[95:64], 32'h33333333);
    q_req.push_back(32'h0);
    grant(4'd7);

    // 6: reset during WAIT; the late tag-7 return must be dropped.
    fetch_en_i = 1'b0;
    reset = 1'b1;
    tick();
    #1;
    check("t6_rst_cmd", proc2Imem_command_o, BUS_NONE);
    reset = 1'b0;
    tick();
    deliver(4'd7, 64'h55555555_66666666);
    tick();
    set_pcs(32'h0, 32'h8, 32'h100);
    fetch_en_i = 1'b1;
    #1;
    check("t6_valid", icache2if_valid_o, 3'b000);
    check("t6_inst",  icache2if_inst_o, 96'd0);
    check("t6_idle_cmd",  proc2Imem_command_o, BUS_LOAD);
    check("t6_idle_addr", proc2Imem_addr_o, 32'h0);
    fetch_en_i = 1'b0;
`endif

    check("sb_empty", q_req.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
